// File: rtl/wm_block_sequencer_if.sv
// Handshake and bus bundle between the config front end, the pixel
// memories/embedding engine and wm_block_sequencer.
interface wm_block_sequencer_if #(
  parameter int Addr_W = 20
);
  logic              go;
  logic [9:0]        img_n;
  logic [9:0]        blk_m;
  logic              out_ready;
  logic              rd_en;
  logic [Addr_W-1:0] rd_addr;
  logic              pix_valid;
  logic              blk_start;
  logic              last_blk;
  logic              wr_en;
  logic [Addr_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output go, img_n, blk_m, out_ready,
    input  rd_en, rd_addr, pix_valid, blk_start, last_blk,
    input  wr_en, wr_addr, busy, done, err
  );

  modport slave (
    input  go, img_n, blk_m, out_ready,
    output rd_en, rd_addr, pix_valid, blk_start, last_blk,
    output wr_en, wr_addr, busy, done, err
  );
endinterface

// File: rtl/wm_block_sequencer.sv
// Walks an NxN image pair in MxM blocks: geometry check, raster read
// addresses, block flags and write strobes aligned to the datapath.
module wm_block_sequencer #(
  parameter int Data_Depth = 8,
  parameter int Addr_W     = 20,
  parameter int LAT        = 1
) (
  input logic clk,
  input logic rst,
  wm_block_sequencer_if.slave bus
);

  if (Data_Depth < 1 || Addr_W < 20 || LAT < 0 || LAT > 7) begin : g_bad_cfg
    $error("wm_block_sequencer: unsupported parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BLK, S_PIX, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [9:0] n_q, m_q, rem, bpr;
  logic [9:0] blk_row, blk_col, r, c;
  logic [Addr_W-1:0] blk_base, row_ptr;
  logic [Addr_W-1:0] n_w, m_w;
  logic [LAT:0] en_line;
  logic [Addr_W-1:0] addr_line [0:LAT];
  logic err_q;
  logic rd_en;
  logic [Addr_W-1:0] rd_addr;
  logic is_last, last_pix, pending;
  logic div_step, div_ok;

  assign n_w = Addr_W'(n_q);
  assign m_w = Addr_W'(m_q);
  assign is_last = (blk_row == bpr - 10'd1) && (blk_col == bpr - 10'd1);
  assign last_pix = (r == m_q - 10'd1) && (c == m_q - 10'd1);
  assign div_step = (rem >= m_q);
  assign div_ok = (rem == '0) && (bpr != '0);
  // Bit 0 is the oldest stage; anything above it still has to leave.
  assign pending = |(en_line >> 1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.go && bus.blk_m != '0) state_nx = S_LOAD;
      S_LOAD: begin
        if (div_step)    state_nx = S_LOAD;
        else if (div_ok) state_nx = S_BLK;
        else             state_nx = S_IDLE;
      end
      S_BLK:   state_nx = S_PIX;
      S_PIX:   if (rd_en && last_pix) state_nx = S_DRAIN;
      S_DRAIN: if (!pending) state_nx = S_NEXT;
      S_NEXT:  state_nx = is_last ? S_DONE : S_BLK;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == S_PIX) && bus.out_ready;
    rd_addr = rd_en ? row_ptr + Addr_W'(c) : '0;
    bus.rd_en = rd_en;
    bus.rd_addr = rd_addr;
    bus.pix_valid = en_line[LAT];
    bus.wr_en = en_line[0];
    bus.wr_addr = addr_line[0];
    bus.blk_start = (state == S_BLK);
    bus.last_blk = is_last &&
      (state == S_BLK || state == S_PIX ||
       state == S_DRAIN || state == S_NEXT);
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
    bus.err = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
      m_q <= '0;
      rem <= '0;
      bpr <= '0;
      blk_row <= '0;
      blk_col <= '0;
      r <= '0;
      c <= '0;
      blk_base <= '0;
      row_ptr <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.go) begin
          n_q <= bus.img_n;
          m_q <= bus.blk_m;
          rem <= bus.img_n;
          bpr <= '0;
          blk_row <= '0;
          blk_col <= '0;
          blk_base <= '0;
          err_q <= (bus.blk_m == '0);
        end
        S_LOAD: begin
          if (div_step) begin
            rem <= rem - m_q;
            bpr <= bpr + 10'd1;
          end else if (!div_ok) begin
            err_q <= 1'b1;
          end
        end
        S_BLK: begin
          row_ptr <= blk_base;
          r <= '0;
          c <= '0;
        end
        S_PIX: if (rd_en) begin
          if (c == m_q - 10'd1) begin
            c <= '0;
            r <= r + 10'd1;
            row_ptr <= row_ptr + n_w;
          end else begin
            c <= c + 10'd1;
          end
        end
        // row_ptr now sits M rows below the block origin, so the next
        // block row starts at row_ptr - (N - M) when the column wraps.
        S_NEXT: begin
          if (blk_col == bpr - 10'd1) begin
            blk_col <= '0;
            blk_row <= blk_row + 10'd1;
            blk_base <= row_ptr - n_w + m_w;
          end else begin
            blk_col <= blk_col + 10'd1;
            blk_base <= blk_base + m_w;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_line <= '0;
      for (int i = 0; i <= LAT; i++) addr_line[i] <= '0;
    end else begin
      en_line[LAT] <= rd_en;
      addr_line[LAT] <= rd_addr;
      for (int i = 0; i < LAT; i++) begin
        en_line[i] <= en_line[i+1];
        addr_line[i] <= addr_line[i+1];
      end
    end
  end

endmodule
